// File: rtl/jtvigil_gfx_rom.sv
// Graphics ROM responder: one-word cache per video client with a single SDRAM req/ack port.
// Optional macro JTVIGIL_GFXROM_FIXPRIO_EN selects fixed priority (obj > scr1 > scr2) instead of round-robin.
module jtvigil_gfx_rom #(
    parameter logic [21:0] SCR1_OFFSET = 22'h00000,
    parameter logic [21:0] SCR2_OFFSET = 22'h20000,
    parameter logic [21:0] OBJ_OFFSET  = 22'h60000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [16:0] scr1_addr,
    input  logic        scr1_cs,
    output logic [31:0] scr1_data,
    output logic        scr1_ok,
    input  logic [17:0] scr2_addr,
    input  logic        scr2_cs,
    output logic [31:0] scr2_data,
    output logic        scr2_ok,
    input  logic [17:0] obj_addr,
    input  logic        obj_cs,
    output logic [31:0] obj_data,
    output logic        obj_ok,
    output logic [21:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [31:0] mem_data
);

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    localparam logic [1:0] ID_SCR1 = 2'd0;
    localparam logic [1:0] ID_SCR2 = 2'd1;
    localparam logic [1:0] ID_OBJ  = 2'd2;

    state_t      state_r;
    logic [2:0]  valid_r;
    logic [16:0] scr1_tag_r;
    logic [17:0] scr2_tag_r;
    logic [17:0] obj_tag_r;
    logic [31:0] scr1_data_r;
    logic [31:0] scr2_data_r;
    logic [31:0] obj_data_r;
    logic [1:0]  req_id_r;
    logic [17:0] req_tag_r;
`ifndef JTVIGIL_GFXROM_FIXPRIO_EN
    logic [1:0]  ptr_r;
`endif

    logic [2:0]  hit_s;
    logic [2:0]  miss_s;
    logic [1:0]  grant_s;
    logic [17:0] grant_addr_s;
    logic [21:0] grant_offset_s;
    logic [21:0] grant_mem_addr_s;

    // The ok flags follow the live address so they drop in the very cycle the address moves off the cached tag
    assign hit_s[0]  = valid_r[0] & (scr1_tag_r == scr1_addr);
    assign hit_s[1]  = valid_r[1] & (scr2_tag_r == scr2_addr);
    assign hit_s[2]  = valid_r[2] & (obj_tag_r  == obj_addr);
    assign miss_s    = {obj_cs, scr2_cs, scr1_cs} & ~hit_s;

    assign scr1_ok   = scr1_cs & hit_s[0];
    assign scr2_ok   = scr2_cs & hit_s[1];
    assign obj_ok    = obj_cs  & hit_s[2];
    assign scr1_data = scr1_data_r;
    assign scr2_data = scr2_data_r;
    assign obj_data  = obj_data_r;

    // Winner selection among missing clients
    always_comb begin
        grant_s = ID_SCR1;
`ifdef JTVIGIL_GFXROM_FIXPRIO_EN
        if (miss_s[2]) begin
            grant_s = ID_OBJ;
        end else if (miss_s[0]) begin
            grant_s = ID_SCR1;
        end else if (miss_s[1]) begin
            grant_s = ID_SCR2;
        end else begin
            grant_s = ID_SCR1;
        end
`else
        // Search starts at the client after the last one served
        case (ptr_r)
            ID_SCR1: begin
                if (miss_s[1])      grant_s = ID_SCR2;
                else if (miss_s[2]) grant_s = ID_OBJ;
                else                grant_s = ID_SCR1;
            end
            ID_SCR2: begin
                if (miss_s[2])      grant_s = ID_OBJ;
                else if (miss_s[0]) grant_s = ID_SCR1;
                else                grant_s = ID_SCR2;
            end
            default: begin
                if (miss_s[0])      grant_s = ID_SCR1;
                else if (miss_s[1]) grant_s = ID_SCR2;
                else                grant_s = ID_OBJ;
            end
        endcase
`endif
    end

    // Address and SDRAM base of the winning client; the sum wraps modulo 2^22
    always_comb begin
        grant_addr_s   = {1'b0, scr1_addr};
        grant_offset_s = SCR1_OFFSET;
        case (grant_s)
            ID_SCR2: begin
                grant_addr_s   = scr2_addr;
                grant_offset_s = SCR2_OFFSET;
            end
            ID_OBJ: begin
                grant_addr_s   = obj_addr;
                grant_offset_s = OBJ_OFFSET;
            end
            default: begin
                grant_addr_s   = {1'b0, scr1_addr};
                grant_offset_s = SCR1_OFFSET;
            end
        endcase
        grant_mem_addr_s = grant_offset_s + {4'd0, grant_addr_s};
    end

    // Request FSM, SDRAM port and cache fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            valid_r     <= 3'b000;
            scr1_tag_r  <= 17'd0;
            scr2_tag_r  <= 18'd0;
            obj_tag_r   <= 18'd0;
            scr1_data_r <= 32'd0;
            scr2_data_r <= 32'd0;
            obj_data_r  <= 32'd0;
            req_id_r    <= ID_SCR1;
            req_tag_r   <= 18'd0;
            mem_addr    <= 22'd0;
            mem_req     <= 1'b0;
`ifndef JTVIGIL_GFXROM_FIXPRIO_EN
            ptr_r       <= ID_SCR1;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|miss_s) begin
                        req_id_r  <= grant_s;
                        req_tag_r <= grant_addr_s;
                        mem_addr  <= grant_mem_addr_s;
                        mem_req   <= 1'b1;
                        state_r   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // The fill keeps the address latched at grant time, even if the client moved on
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state_r <= ST_IDLE;
`ifndef JTVIGIL_GFXROM_FIXPRIO_EN
                        ptr_r   <= req_id_r;
`endif
                        case (req_id_r)
                            ID_SCR2: begin
                                valid_r[1]  <= 1'b1;
                                scr2_tag_r  <= req_tag_r;
                                scr2_data_r <= mem_data;
                            end
                            ID_OBJ: begin
                                valid_r[2]  <= 1'b1;
                                obj_tag_r   <= req_tag_r;
                                obj_data_r  <= mem_data;
                            end
                            default: begin
                                valid_r[0]  <= 1'b1;
                                scr1_tag_r  <= req_tag_r[16:0];
                                scr1_data_r <= mem_data;
                            end
                        endcase
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
